// File: rtl/alu_result_stage.sv
// Buffered writeback stage behind the 16-bit ALU: tags each result with
// zero/negative/overflow flags at capture and releases them in order to the register file.
`timescale 1ns/1ps

module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [3:0]               in_op,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  input  logic [TAG_W-1:0]         in_dest,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [TAG_W-1:0]         out_dest,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_stage: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  dest;
    logic              zero;
    logic              neg;
    logic              ovf;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  entry_t           mem_q [DEPTH];
  entry_t           wr_entry_d;
  entry_t           head;
  logic             push;
  logic             pop;

  // Handshake depends only on registered level, so in_ready never waits on out_ready.
  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_entry_d        = '0;
    wr_entry_d.result = in_result;
    wr_entry_d.dest   = in_dest;
    wr_entry_d.zero   = (in_result == '0);
    wr_entry_d.neg    = in_result[DATA_W-1];
    if (in_op[3:2] == 2'b00) begin
      case (in_op[1:0])
        2'b00:   wr_entry_d.ovf = (in_a_msb == in_b_msb) && (in_result[DATA_W-1] != in_a_msb);
        2'b01:   wr_entry_d.ovf = (in_a_msb != in_b_msb) && (in_result[DATA_W-1] != in_a_msb);
        default: wr_entry_d.ovf = 1'b0;
      endcase
    end
  end

  // Flush wins over push and pop; the entry offered in a flush cycle is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the level counter alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry_d;
  end

  // Outputs are zeroed while empty so stale slots never leak to the register file.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_result = '0;
    out_dest   = '0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    out_ovf    = 1'b0;
    if (out_valid) begin
      out_result = head.result;
      out_dest   = head.dest;
      out_zero   = head.zero;
      out_neg    = head.neg;
      out_ovf    = head.ovf;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus random traffic,
// checked against an operand-level ALU/flag model and an in-order queue.
`timescale 1ns/1ps

module tb_alu_result_stage;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int DEPTH  = 2;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_op;
  logic              in_a_msb;
  logic              in_b_msb;
  logic [TAG_W-1:0]  in_dest;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_dest;
  logic              out_zero;
  logic              out_neg;
  logic              out_ovf;
  logic [LVL_W-1:0]  level;

  alu_result_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_op     (in_op),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .in_dest   (in_dest),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_dest  (out_dest),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [2:0]  dest;
  } item_t;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  dest;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   exp_level = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   pops_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_ref(input item_t it);
    case (it.op[1:0])
      2'd0:    return it.a + it.b;
      2'd1:    return it.a - it.b;
      2'd2:    return it.a & it.b;
      default: return it.a | it.b;
    endcase
  endfunction

  // Overflow from true signed arithmetic on the operands, not from sign bits.
  function automatic exp_t predict(input item_t it);
    exp_t e;
    int sa, sbv, r;
    sa       = int'($signed(it.a));
    sbv      = int'($signed(it.b));
    e.result = alu_ref(it);
    e.dest   = it.dest;
    e.zero   = (e.result == 16'd0);
    e.neg    = e.result[15];
    e.ovf    = 1'b0;
    if (it.op[3:2] == 2'b00) begin
      if (it.op[1:0] == 2'd0) begin
        r = sa + sbv;
        e.ovf = (r > 32767) || (r < -32768);
      end else if (it.op[1:0] == 2'd1) begin
        r = sa - sbv;
        e.ovf = (r > 32767) || (r < -32768);
      end
    end
    return e;
  endfunction

  function automatic item_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op, input logic [2:0] dest);
    item_t it;
    it.a = a; it.b = b; it.op = op; it.dest = dest;
    return it;
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner [4];
    corner[0] = 16'h7FFF; corner[1] = 16'h8000; corner[2] = 16'hFFFF; corner[3] = 16'h0000;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.a       = pick_operand();
    it.b       = pick_operand();
    it.op[1:0] = 2'($urandom_range(0, 3));
    it.op[3:2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    it.dest    = 3'($urandom_range(0, 7));
    return it;
  endfunction

  // One clock cycle of stimulus, entered and left at posedge+1. The queue
  // and expected level follow the handshake rules independently of the DUT.
  task automatic cycle(input bit v, input item_t it, input bit ordy, input bit fl, output bit acc);
    bit pop_m;
    in_valid  = v;
    in_result = alu_ref(it);
    in_op     = it.op;
    in_a_msb  = it.a[15];
    in_b_msb  = it.b[15];
    in_dest   = it.dest;
    out_ready = ordy;
    flush     = fl;
    acc   = v && !fl && (exp_level < DEPTH);
    pop_m = ordy && !fl && (exp_level > 0);
    if (acc) sb.push_back(predict(it));
    @(posedge clk);
    #1;
    if (fl) exp_level = 0;
    else    exp_level = exp_level + int'(acc) - int'(pop_m);
  endtask

  // Monitor: per-cycle status checks and in-order comparison of every handshake.
  always @(negedge clk) begin
    if (!reset) begin
      check("level", 32'(level), 32'(exp_level));
      check("out_valid", 32'(out_valid), 32'(exp_level != 0));
      check("in_ready", 32'(in_ready), 32'(exp_level != DEPTH));
      check("level_range", 32'(level <= LVL_W'(DEPTH)), 32'd1);
      if (in_valid && in_ready) check("push_not_full", 32'(level < LVL_W'(DEPTH)), 32'd1);
      if (out_valid && out_ready) check("pop_not_empty", 32'(level != '0), 32'd1);
      if (!out_valid)
        check("idle_zero", 32'({out_result, out_dest, out_zero, out_neg, out_ovf}), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=%0h expected=no entry at %0t", out_result, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_result", 32'(out_result), 32'(e.result));
          check("out_dest", 32'(out_dest), 32'(e.dest));
          check("out_zero", 32'(out_zero), 32'(e.zero));
          check("out_neg", 32'(out_neg), 32'(e.neg));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
          pops_seen++;
        end
      end
      if (flush) sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    item_t idle;
    item_t cur;
    bit    have;
    bit    acc;
    int    pops_start;

    idle      = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_op     = '0;
    in_a_msb  = 1'b0;
    in_b_msb  = 1'b0;
    in_dest   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // 1. Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_outputs", 32'({out_result, out_dest, out_zero, out_neg, out_ovf}), 32'd0);
    reset = 1'b0;
    cycle(0, idle, 0, 0, acc);

    // 2. Add overflow, then a zero result from subtract.
    cycle(1, mk(16'h7FFF, 16'h0001, 4'b0000, 3'd5), 1, 0, acc);
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_out_result", 32'(out_result), 32'h8000);
    check("add_flags", 32'({out_dest, out_zero, out_neg, out_ovf}), 32'({3'd5, 1'b0, 1'b1, 1'b1}));
    cycle(1, mk(16'h0005, 16'h0005, 4'b0001, 3'd2), 1, 0, acc);
    check("sub_zero_flags", 32'({out_result, out_zero, out_ovf}), 32'({16'h0000, 1'b1, 1'b0}));
    cycle(0, idle, 1, 0, acc);

    // 3. Backpressure and full.
    cycle(1, mk(16'h0001, 16'h0000, 4'b0000, 3'd1), 0, 0, acc);
    cycle(1, mk(16'h0002, 16'h0000, 4'b0000, 3'd2), 0, 0, acc);
    check("full_level", 32'(level), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1, mk(16'h0003, 16'h0000, 4'b0000, 3'd3), 0, 0, acc);
    check("full_hold_head", 32'(out_result), 32'h0001);
    cycle(1, mk(16'h0003, 16'h0000, 4'b0000, 3'd3), 1, 0, acc);
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    check("after_pop_head", 32'(out_result), 32'h0002);
    cycle(1, mk(16'h0003, 16'h0000, 4'b0000, 3'd3), 0, 0, acc);
    check("third_accepted_level", 32'(level), 32'd2);
    repeat (2) cycle(0, idle, 1, 0, acc);

    // 4. Streaming across pointer wrap.
    pops_start = pops_seen;
    for (int i = 0; i < 7; i++)
      cycle(1, mk(16'h0010 + 16'(i), 16'h0000, 4'b0011, 3'(i)), 1, 0, acc);
    cycle(0, idle, 1, 0, acc);
    check("stream_pops", 32'(pops_seen - pops_start), 32'd7);

    // 5. Flush priority over push and pop.
    cycle(1, mk(16'h0101, 16'h0000, 4'b0011, 3'd1), 0, 0, acc);
    cycle(1, mk(16'h0202, 16'h0000, 4'b0011, 3'd2), 0, 0, acc);
    cycle(1, mk(16'h0303, 16'h0000, 4'b0011, 3'd3), 1, 1, acc);
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (3) cycle(0, idle, 1, 0, acc);

    // 6. Asynchronous reset between edges.
    cycle(1, mk(16'h0055, 16'h0000, 4'b0011, 3'd4), 0, 0, acc);
    cycle(1, mk(16'h0066, 16'h0000, 4'b0011, 3'd6), 0, 0, acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    exp_level = 0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_result", 32'(out_result), 32'd0);
    check("areset_level", 32'(level), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, mk(16'h00AA, 16'h0000, 4'b0011, 3'd7), 0, 0, acc);
    check("resume_result", 32'(out_result), 32'h00AA);
    cycle(0, idle, 1, 0, acc);

    // Random traffic with held offers, random backpressure and occasional flush.
    have = 1'b0;
    cur  = idle;
    for (int n = 0; n < 400; n++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        cur  = rand_item();
        have = 1'b1;
      end
      cycle(have, cur, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, acc);
      if (acc || flush) have = 1'b0;
    end
    repeat (DEPTH + 2) cycle(0, idle, 1, 0, acc);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Buffered writeback stage directly downstream of the 16-bit combinational ALU (ops: 00 add, 01 sub, 10 and, 11 or).
- Captures the ALU result with its destination register tag, and derives zero, negative and signed-overflow flags at capture time.
- Holds captured entries in a small in-order FIFO and releases them to the register-file write port over a valid/ready handshake.
- Decouples the single-cycle ALU from register-file write stalls.

Parameters:
- DATA_W, 16: result width; must match the ALU width.
- TAG_W, 3: destination register tag width (8 registers).
- DEPTH, 2: FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result on in_result is valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  DATA_W  ALU out.
- in_op  input  4  op applied to the ALU this cycle.
- in_a_msb  input  1  bit DATA_W-1 of ALU input_a.
- in_b_msb  input  1  bit DATA_W-1 of ALU input_b.
- in_dest  input  TAG_W  destination register tag.
- flush  input  1  synchronous discard of all buffered entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file accepts head entry.
- out_result  output  DATA_W  head result.
- out_dest  output  TAG_W  head tag.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- out_ovf  output  1  head signed overflow.
- level  output  log2(DEPTH)+1  number of buffered entries.

Behaviour:
- Reset (async assert, sampled deassert at clk):
  - Read/write pointers and level are 0.
  - out_valid=0, in_ready=1.
  - out_result, out_dest, out_zero, out_neg, out_ovf are all 0.
- Data outputs while empty: out_result, out_dest and all flags are forced to 0 whenever out_valid=0 (no stale data).
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (level != DEPTH). It depends on registered state only, never on out_ready.
  - out_valid = (level != 0).
- Latency: an entry pushed at edge N appears on the outputs after edge N (1 cycle). There is no combinational bypass from in_* to out_*.
- Flag computation at push, stored with the entry:
  - zero = (in_result == 0).
  - neg = in_result[DATA_W-1].
  - ovf for op[1:0]=00 (add): (a_msb == b_msb) & (res_msb != a_msb).
  - ovf for op[1:0]=01 (sub): (a_msb != b_msb) & (res_msb != a_msb).
  - ovf for and/or: 0.
  - If op[3:2] != 0, ovf = 0; zero and neg are still computed.
- Simultaneous push and pop when 0 < level < DEPTH: both occur and level is unchanged.
- Full: push cannot occur; a pop in the same cycle frees the slot, and in_ready rises on the next cycle.
- Empty: a pop cannot occur; a push makes out_valid=1 on the next cycle.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO across wrap-around.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Resets pointers and level to 0; the entry offered that cycle is dropped.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: all entries are lost immediately (asynchronously) and outputs return to their reset values without waiting for clk.
- Level is never observed outside 0..DEPTH. A push while full or a pop while empty is impossible by construction; the bench must assert this.

Test Plan:
1. Reset and idle: assert reset for 3 cycles with in_valid=0 -> out_valid=0, in_ready=1, level=0, out_result=0x0000, all flags 0.
2. Add overflow:
   - Push in_result=0x8000, op=0000, a_msb=0, b_msb=0 (0x7FFF+0x0001), dest=5, with out_ready=1.
   - Next cycle -> out_valid=1, out_result=0x8000, out_dest=5, neg=1, ovf=1, zero=0.
   - Then push in_result=0x0000, op=0001, a_msb=0, b_msb=0 -> zero=1, ovf=0.
3. Backpressure and full:
   - Hold out_ready=0 and push 3 entries (0x0001, 0x0002, 0x0003) back-to-back.
   - After 2 pushes -> level=2, in_ready=0; third entry is held at the input.
   - Raise out_ready for 1 cycle -> 0x0001 popped; in_ready=1 the next cycle; 0x0003 then accepted.
4. Streaming and wrap: with out_ready=1, push 7 consecutive entries 0x0010..0x0016 -> out_result sequence is identical and in order, level never exceeds 1, no bubbles after the first.
5. Flush priority: with level=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0; neither the flushed entries nor the offered entry ever appear on the outputs.
6. Async reset mid-stream: with level=2, assert reset between clock edges -> out_valid=0, out_result=0x0000 before the next edge; after release, operation resumes correctly with a new push of 0x00AA.
